// File: rtl/display_value_scheduler.sv
// Round-robin display arbiter: picks one of three signed requesters, converts the
// magnitude to five BCD digits by double-dabble and holds the result on display.
module display_value_scheduler #(
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic signed [14:0]       val0,
  input  logic signed [14:0]       val1,
  input  logic signed [14:0]       val2,
  output logic [2:0]               ack,
  output logic                     busy,
  output logic [3:0]               bcd0,
  output logic [3:0]               bcd1,
  output logic [3:0]               bcd2,
  output logic [3:0]               bcd3,
  output logic [3:0]               bcd4,
  output logic                     neg,
  output logic [1:0]               src,
  output logic                     valid
);
  localparam int DATA_W = 15;
  localparam int BCD_W  = 20;
  localparam int CNT_W  = 26;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

  state_t                    state;
  logic [BCD_W-1:0]          acc;
  logic [DATA_W-1:0]         mag;
  logic [3:0]                shift_cnt;
  logic [CNT_W-1:0]          hold_cnt;
  logic [1:0]                last;
  logic [1:0]                grant;
  logic                      neg_cap;
  logic [1:0]                pick;
  logic signed [DATA_W-1:0]  pick_val;
  logic [BCD_W+DATA_W-1:0]   shifted;

  // Unsigned magnitude; -16384 maps to 16384, which still fits in 15 unsigned bits.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return u[DATA_W-1] ? (~u + DATA_W'(1)) : u;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Search order last+1, last+2, last; the nearest requesting index wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lst);
    logic [1:0] c;
    logic [1:0] p;
    p = lst;
    for (int k = 3; k >= 1; k--) begin
      c = 2'((int'(lst) + k) % 3);
      if (r[c]) p = c;
    end
    return p;
  endfunction

  always_comb begin
    pick = rr_pick(req, last);
    case (pick)
      2'd0:    pick_val = val0;
      2'd1:    pick_val = val1;
      default: pick_val = val2;
    endcase
    shifted = {dabble_adjust(acc), mag} << 1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      mag       <= '0;
      shift_cnt <= '0;
      hold_cnt  <= '0;
      last      <= 2'd2;
      grant     <= '0;
      neg_cap   <= 1'b0;
      ack       <= '0;
      {bcd4, bcd3, bcd2, bcd1, bcd0} <= '0;
      neg       <= 1'b0;
      src       <= '0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= pick;
            last      <= pick;
            neg_cap   <= pick_val[DATA_W-1];
            mag       <= magnitude(pick_val);
            acc       <= '0;
            shift_cnt <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc       <= shifted[BCD_W+DATA_W-1:DATA_W];
          mag       <= shifted[DATA_W-1:0];
          shift_cnt <= shift_cnt + 4'd1;
          // Final shift lands straight on the display so partial values never show.
          if (shift_cnt == 4'd14) begin
            {bcd4, bcd3, bcd2, bcd1, bcd0} <= shifted[BCD_W+DATA_W-1:DATA_W];
            neg   <= neg_cap;
            src   <= grant;
            valid <= 1'b1;
            ack   <= 3'b001 << grant;
            state <= DONE;
          end
        end
        DONE: begin
          ack      <= '0;
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) state <= IDLE;
          else hold_cnt <= hold_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_value_scheduler.sv
// Directed bench for display_value_scheduler with HOLD_CYCLES=4.
module tb_display_value_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req;
  logic signed [14:0] val0, val1, val2;
  logic [2:0] ack;
  logic busy;
  logic [3:0] bcd0, bcd1, bcd2, bcd3, bcd4;
  logic neg;
  logic [1:0] src;
  logic valid;
  logic [19:0] disp;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign disp = {bcd4, bcd3, bcd2, bcd1, bcd0};

  display_value_scheduler #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
    .ack(ack), .busy(busy), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .bcd4(bcd4), .neg(neg), .src(src), .valid(valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ack(input string tag, input int exp_lat);
    logic [19:0] prev;
    int lat;
    prev = disp;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 8) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_disp_held"}, 32'(disp), 32'(prev));
      end
      if (ack != 3'b000) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 40; n++) begin
      if (!busy) break;
      @(posedge clk); @(negedge clk);
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic conv(input string tag, input logic [2:0] r, input logic [19:0] exp_bcd,
                      input logic exp_neg, input logic [1:0] exp_src);
    req = r;
    wait_ack(tag, 16);
    chk({tag, "_ack"}, 32'(ack), 32'(3'b001 << exp_src));
    chk({tag, "_bcd"}, 32'(disp), 32'(exp_bcd));
    chk({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    chk({tag, "_src"}, 32'(src), 32'(exp_src));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    req = 3'b000;
    @(posedge clk); @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    wait_idle(tag);
  endtask

  int t_ev[4];
  logic [2:0] a_ev[4];
  logic [1:0] s_ev[4];
  logic [19:0] d_ev[4];
  int events;

  initial begin
    rst = 1'b0; req = 3'b000; val0 = '0; val1 = '0; val2 = '0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(disp), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    val0 = 15'd12345;
    conv("pos12345", 3'b001, 20'h12345, 1'b0, 2'd0);
    val1 = 15'h7FFF;
    conv("minus1", 3'b010, 20'h00001, 1'b1, 2'd1);
    val0 = 15'h4000;
    conv("min_neg", 3'b001, 20'h16384, 1'b1, 2'd0);
    val0 = 15'h3FFF;
    conv("max_pos", 3'b001, 20'h16383, 1'b0, 2'd0);

    // Zero result, req dropped and val changed right after the grant edge
    val2 = '0;
    req = 3'b100;
    @(posedge clk); @(negedge clk);
    req = 3'b000;
    val2 = 15'd777;
    wait_ack("zero", 15);
    chk("zero_ack", 32'(ack), 32'h4);
    chk("zero_bcd", 32'(disp), 32'd0);
    chk("zero_neg", 32'(neg), 32'd0);
    chk("zero_src", 32'(src), 32'd2);
    @(posedge clk); @(negedge clk);
    chk("zero_ack_pulse", 32'(ack), 32'd0);
    wait_idle("zero");

    // Continuous requests from all three: round-robin at 17+4 cycle spacing
    val0 = 15'd1; val1 = 15'd2; val2 = 15'd3;
    req = 3'b111;
    events = 0;
    for (int n = 1; n <= 95; n++) begin
      @(posedge clk); @(negedge clk);
      if (ack != 3'b000) begin
        if (events < 4) begin
          t_ev[events] = n; a_ev[events] = ack; s_ev[events] = src; d_ev[events] = disp;
        end
        events++;
      end
    end
    req = 3'b000;
    chk("rr_events", 32'(events), 32'd4);
    chk("rr_first_lat", 32'(t_ev[0]), 32'd16);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), 32'(t_ev[i] - t_ev[i-1]), 32'd21);
    chk("rr_ack0", 32'(a_ev[0]), 32'h1);
    chk("rr_ack1", 32'(a_ev[1]), 32'h2);
    chk("rr_ack2", 32'(a_ev[2]), 32'h4);
    chk("rr_ack3", 32'(a_ev[3]), 32'h1);
    chk("rr_src0", 32'(s_ev[0]), 32'd0);
    chk("rr_src1", 32'(s_ev[1]), 32'd1);
    chk("rr_src2", 32'(s_ev[2]), 32'd2);
    chk("rr_src3", 32'(s_ev[3]), 32'd0);
    chk("rr_bcd1", 32'(d_ev[1]), 32'h00002);
    chk("rr_bcd2", 32'(d_ev[2]), 32'h00003);
    wait_idle("rr");

    // Reset in the middle of a conversion
    val0 = 15'd999;
    req = 3'b001;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("mid_noack", 32'(ack), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bcd", 32'(disp), 32'd0);
    chk("mid_rst_neg", 32'(neg), 32'd0);
    chk("mid_rst_src", 32'(src), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    repeat (2) @(negedge clk);
    req = 3'b011;
    rst = 1'b1;
    wait_ack("after_rst", 16);
    chk("after_rst_ack", 32'(ack), 32'h1);
    chk("after_rst_src", 32'(src), 32'd0);
    chk("after_rst_bcd", 32'(disp), 32'h00999);
    req = 3'b000;
    wait_idle("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
